// File: rtl/hyperbus_req_scheduler_pkg.sv
// hyperbus_sched_pkg: shared types and default parameters for the HyperBus request scheduler.
package hyperbus_sched_pkg;
    localparam int DefNumReq        = 3;
    localparam int DefAddrWidth     = 32;
    localparam int DefLenWidth      = 8;
    localparam int DefRecoverCycles = 4;
    localparam int DefMaxRtStreak   = 4;
    localparam int DefTimeoutCycles = 1024;

    typedef enum logic [1:0] {IDLE, CMD, XFER, RECOVER} sched_state_e;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic                    write;
        logic [DefLenWidth-1:0]  len;
    } hb_cmd_t;
endpackage

// File: rtl/hyperbus_req_scheduler_rr_pick.sv
// hyperbus_rr_pick: first valid index at or after ptr, wrapping to the lowest valid index.
module hyperbus_rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx
);
    logic [N-1:0] masked;

    always_comb begin
        masked = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) masked[i] = valid[i] && (i >= int'(ptr));
        for (int i = N - 1; i >= 0; i--) if (valid[i]) idx = W'(i);
        for (int i = N - 1; i >= 0; i--) if (masked[i]) idx = W'(i);
    end
endmodule

// File: rtl/hyperbus_req_scheduler.sv
// hyperbus_req_scheduler: shares one HyperBus PHY command channel among requesters with
// RT-first round-robin arbitration, a non-RT starvation bound, a CS# recovery gap and a watchdog.
module hyperbus_req_scheduler
    import hyperbus_sched_pkg::*;
#(
    parameter int NumReq        = DefNumReq,
    parameter int AddrWidth     = DefAddrWidth,
    parameter int LenWidth      = DefLenWidth,
    parameter int RecoverCycles = DefRecoverCycles,
    parameter int MaxRtStreak   = DefMaxRtStreak,
    parameter int TimeoutCycles = DefTimeoutCycles
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_rt_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*LenWidth-1:0]    req_len_i,
    output logic                          phy_valid_o,
    input  logic                          phy_ready_i,
    output logic [AddrWidth-1:0]          phy_addr_o,
    output logic                          phy_write_o,
    output logic [LenWidth-1:0]           phy_len_o,
    input  logic                          phy_done_i,
    output logic [$clog2(NumReq)-1:0]     grant_id_o,
    output logic                          busy_o,
    output logic                          timeout_o
);
    localparam int IdW = $clog2(NumReq);
    localparam int StW = $clog2(MaxRtStreak + 1);
    localparam int WdW = $clog2(TimeoutCycles + 1);
    localparam int RcW = $clog2(RecoverCycles + 1);

    sched_state_e      state, state_d;
    hb_cmd_t           cmd_q;
    logic [IdW-1:0]    win, win_q, ptr_rt, ptr_nrt, rt_idx, nrt_idx, ptr_nxt;
    logic [NumReq-1:0] rt_valid, nrt_valid;
    logic [StW-1:0]    streak;
    logic [WdW-1:0]    wdog;
    logic [RcW-1:0]    rcnt;
    logic              rt_q, use_nrt, accept, wd_fire;

    assign rt_valid  = req_valid_i & req_rt_i;
    assign nrt_valid = req_valid_i & ~req_rt_i;

    hyperbus_rr_pick #(.N(NumReq)) u_rt_pick  (.valid(rt_valid),  .ptr(ptr_rt),  .idx(rt_idx));
    hyperbus_rr_pick #(.N(NumReq)) u_nrt_pick (.valid(nrt_valid), .ptr(ptr_nrt), .idx(nrt_idx));

    // A full RT streak yields to waiting non-RT ports; an empty RT class also falls back to non-RT.
    assign use_nrt = (|nrt_valid && streak == StW'(MaxRtStreak)) || ~|rt_valid;
    assign win     = use_nrt ? nrt_idx : rt_idx;
    assign accept  = state == CMD && phy_ready_i;
    assign wd_fire = state == XFER && wdog == WdW'(TimeoutCycles - 1);
    assign ptr_nxt = (win_q == IdW'(NumReq - 1)) ? '0 : win_q + IdW'(1);

    assign phy_valid_o = state == CMD;
    assign req_ready_o = accept ? NumReq'(1) << win_q : '0;
    assign phy_addr_o  = AddrWidth'(cmd_q.addr);
    assign phy_write_o = cmd_q.write;
    assign phy_len_o   = LenWidth'(cmd_q.len);
    assign grant_id_o  = win_q;
    assign busy_o      = state != IDLE;
    assign timeout_o   = wd_fire && !phy_done_i;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = |req_valid_i ? CMD : IDLE;
            CMD:     state_d = phy_ready_i ? XFER : CMD;
            XFER:    state_d = (phy_done_i || wd_fire) ? RECOVER : XFER;
            RECOVER: state_d = (rcnt == RcW'(RecoverCycles - 1)) ? IDLE : RECOVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cmd_q   <= '0;
            win_q   <= '0;
            rt_q    <= 1'b0;
            ptr_rt  <= '0;
            ptr_nrt <= '0;
            streak  <= '0;
            wdog    <= '0;
            rcnt    <= '0;
        end else begin
            if (state == IDLE && |req_valid_i) begin
                win_q <= win;
                rt_q  <= req_rt_i[win];
                cmd_q <= '{addr:  DefAddrWidth'(req_addr_i[win*AddrWidth +: AddrWidth]),
                           write: req_write_i[win],
                           len:   DefLenWidth'(req_len_i[win*LenWidth +: LenWidth])};
            end
            if (accept) begin
                if (rt_q) ptr_rt <= ptr_nxt;
                else ptr_nrt <= ptr_nxt;
                streak <= !rt_q ? '0 : (streak == StW'(MaxRtStreak)) ? streak : streak + StW'(1);
            end
            wdog <= (state == XFER) ? wdog + WdW'(1) : '0;
            rcnt <= (state == RECOVER) ? rcnt + RcW'(1) : '0;
        end

    // The latched command is only valid while its requester keeps holding the request.
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        state == CMD |-> req_valid_i[win_q]);
endmodule
